playfield_mem: RTL and testbench

//  Parametrised successor to the per-cell memcell column: a WIDTH x HEIGHT

---
 rtl/playfield_mem.sv | 122 ++++++++++++
 tb/tb_playfield_mem.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/playfield_mem.sv
// Tetris playfield: WIDTH x HEIGHT colour cells with write/read ports
// and a bottom-up line-clear engine that collapses full rows.
module playfield_mem #(
  parameter int WIDTH   = 10,
  parameter int HEIGHT  = 20,
  parameter int COLOR_W = 3,
  parameter int XW      = 4,
  parameter int YW      = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [XW-1:0]      wr_x,
  input  logic [YW-1:0]      wr_y,
  input  logic [COLOR_W-1:0] wr_color,
  input  logic [XW-1:0]      rd_x,
  input  logic [YW-1:0]      rd_y,
  output logic [COLOR_W-1:0] rd_color,
  output logic               rd_occ,
  input  logic               clear_start,
  output logic               busy,
  output logic               done,
  output logic [YW-1:0]      lines_cleared,
  output logic               top_occ
);

  localparam logic [XW-1:0] XMAX = XW'(WIDTH - 1);
  localparam logic [YW-1:0] YMAX = YW'(HEIGHT - 1);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    SHIFT,
    DONE
  } state_t;

  typedef logic [HEIGHT-1:0][WIDTH-1:0][COLOR_W-1:0] board_t;

  state_t          state_q, state_d;
  board_t          cells_q, cells_d;
  logic [YW-1:0]   r_q, r_d;
  logic [YW-1:0]   cnt_q, cnt_d;
  logic [YW-1:0]   lines_q, lines_d;
  logic            row_full;
  logic            rd_ok;
  logic            wr_ok;

  assign rd_ok = (rd_x <= XMAX) && (rd_y <= YMAX);
  assign wr_ok = (wr_x <= XMAX) && (wr_y <= YMAX);

  assign rd_color      = rd_ok ? cells_q[rd_y][rd_x] : '0;
  assign rd_occ        = (rd_color != '0);
  assign top_occ       = |cells_q[0];
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);
  assign lines_cleared = lines_q;

  always_comb begin
    row_full = 1'b1;
    for (int x = 0; x < WIDTH; x++) begin
      if (cells_q[r_q][x] == '0) row_full = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    cells_d = cells_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    lines_d = lines_q;
    unique case (state_q)
      IDLE: begin
        // a write in the start cycle lands before the first scan
        if (wr_en && wr_ok) cells_d[wr_y][wr_x] = wr_color;
        if (clear_start) begin
          state_d = SCAN;
          r_d     = YMAX;
          cnt_d   = '0;
        end
      end
      SCAN: begin
        if (row_full) begin
          state_d = SHIFT;
        end else if (r_q == '0) begin
          state_d = DONE;
        end else begin
          r_d = r_q - 1'b1;
        end
      end
      SHIFT: begin
        for (int y = 1; y < HEIGHT; y++) begin
          if (YW'(y) <= r_q) cells_d[y] = cells_q[y-1];
        end
        cells_d[0] = '0;
        cnt_d      = cnt_q + 1'b1;
        state_d    = SCAN;
      end
      DONE: begin
        lines_d = cnt_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cells_q <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      lines_q <= '0;
    end else begin
      state_q <= state_d;
      cells_q <= cells_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      lines_q <= lines_d;
    end
  end

endmodule

// File: tb/tb_playfield_mem.sv
// Bench for playfield_mem: compaction model checked every cycle
// plus directed scenarios with literal expectations.
module tb_playfield_mem;

  localparam int W  = 10;
  localparam int H  = 20;
  localparam int CW = 3;
  localparam int XW = 4;
  localparam int YW = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          wr_en = 1'b0;
  logic [XW-1:0] wr_x = '0;
  logic [YW-1:0] wr_y = '0;
  logic [CW-1:0] wr_color = '0;
  logic [XW-1:0] rd_x = '0;
  logic [YW-1:0] rd_y = '0;
  logic [CW-1:0] rd_color;
  logic          rd_occ;
  logic          clear_start = 1'b0;
  logic          busy;
  logic          done;
  logic [YW-1:0] lines_cleared;
  logic          top_occ;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  playfield_mem #(
    .WIDTH(W), .HEIGHT(H), .COLOR_W(CW), .XW(XW), .YW(YW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .wr_en(wr_en),
    .wr_x(wr_x),
    .wr_y(wr_y),
    .wr_color(wr_color),
    .rd_x(rd_x),
    .rd_y(rd_y),
    .rd_color(rd_color),
    .rd_occ(rd_occ),
    .clear_start(clear_start),
    .busy(busy),
    .done(done),
    .lines_cleared(lines_cleared),
    .top_occ(top_occ)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Model: board as plain array; a clear is computed at once by
  // keeping non-full rows bottom-aligned, and only the timing is waited.
  int  mb   [H][W];
  int  pend [H][W];
  int  m_rem = 0;
  int  m_k = 0;
  int  m_lines = 0;
  int  dst;
  bit  full;

  always @(posedge clk) begin
    if (!reset) begin
      for (int y = 0; y < H; y++)
        for (int x = 0; x < W; x++) mb[y][x] = 0;
      m_rem = 0;
      m_lines = 0;
    end else if (m_rem == 0) begin
      if (wr_en && int'(wr_x) < W && int'(wr_y) < H)
        mb[wr_y][wr_x] = int'(wr_color);
      if (clear_start) begin
        for (int y = 0; y < H; y++)
          for (int x = 0; x < W; x++) pend[y][x] = 0;
        m_k = 0;
        dst = H - 1;
        for (int y = H - 1; y >= 0; y--) begin
          full = 1'b1;
          for (int x = 0; x < W; x++) if (mb[y][x] == 0) full = 1'b0;
          if (full) m_k++;
          else begin
            for (int x = 0; x < W; x++) pend[dst][x] = mb[y][x];
            dst--;
          end
        end
        m_rem = H + 1 + 2 * m_k;
      end
    end else begin
      m_rem--;
      if (m_rem == 0) begin
        mb = pend;
        m_lines = m_k;
      end
    end
  end

  int e_rd;
  int e_top;
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", int'(busy), int'(m_rem != 0));
      chk("done", int'(done), int'(m_rem == 1));
      chk("lines_cleared", int'(lines_cleared), m_lines);
      if (m_rem == 0) begin
        e_rd = (int'(rd_x) < W && int'(rd_y) < H) ? mb[rd_y][rd_x] : 0;
        e_top = 0;
        for (int x = 0; x < W; x++) if (mb[0][x] != 0) e_top = 1;
        chk("rd_color", int'(rd_color), e_rd);
        chk("rd_occ", int'(rd_occ), int'(e_rd != 0));
        chk("top_occ", int'(top_occ), e_top);
      end
    end
  end

  task automatic wr(input int x, input int y, input int c);
    @(posedge clk); #1;
    wr_en = 1'b1;
    wr_x = XW'(x);
    wr_y = YW'(y);
    wr_color = CW'(c);
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic fill_row(input int y, input int c);
    for (int x = 0; x < W; x++) wr(x, y, c);
  endtask

  task automatic rd_chk(input string nm, input int x, input int y,
                        input int exp);
    rd_x = XW'(x);
    rd_y = YW'(y);
    #1;
    chk(nm, int'(rd_color), exp);
  endtask

  function automatic int exp_cell(input int mode, input int x, input int y);
    if (mode == 1) return (x == 0 && y == 19) ? 2 : 0;
    if (mode == 2) begin
      if (x == 2 && y == 19) return 4;
      if (x == 5 && y == 18) return 3;
    end
    return 0;
  endfunction

  task automatic sweep(input string nm, input int mode);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) rd_chk(nm, x, y, exp_cell(mode, x, y));
  endtask

  // Pulse clear_start (cycle 0), report done cycle, then lines_cleared.
  task automatic run_clear(input string nm, input int exp_cyc,
                           input int exp_lines, input bit inject);
    int cyc;
    int got;
    got = -1;
    @(posedge clk); #1;
    clear_start = 1'b1;
    @(posedge clk); #1;
    clear_start = 1'b0;
    cyc = 1;
    while (cyc < 100 && got < 0) begin
      if (inject && cyc == 2) begin
        wr_en = 1'b1;
        wr_x = '0;
        wr_y = '0;
        wr_color = 3'd7;
        clear_start = 1'b1;
      end
      if (inject && cyc == 5) begin
        wr_en = 1'b0;
        clear_start = 1'b0;
      end
      @(negedge clk);
      if (done) got = cyc;
      @(posedge clk); #1;
      cyc++;
    end
    chk({nm, "_done_cycle"}, got, exp_cyc);
    @(negedge clk);
    chk({nm, "_lines"}, int'(lines_cleared), exp_lines);
  endtask

  initial begin
    int seen;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    chk_en = 1'b1;

    // 1: reset state over the full coordinate space
    for (int y = 0; y < 32; y++)
      for (int x = 0; x < 16; x++) rd_chk("reset_rd", x, y, 0);
    chk("reset_top_occ", int'(top_occ), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_lines", int'(lines_cleared), 0);

    // 2: basic write/read and out-of-range writes
    wr(3, 7, 5);
    rd_chk("wr_3_7", 3, 7, 5);
    chk("occ_3_7", int'(rd_occ), 1);
    wr(10, 7, 6);
    rd_chk("wr_x_oob", 10, 7, 0);
    rd_chk("wr_x_oob_wrap", 0, 7, 0);
    wr(3, 20, 6);
    rd_chk("wr_y_oob", 3, 20, 0);
    wr(3, 7, 0);
    rd_chk("erase_3_7", 3, 7, 0);
    chk("erase_occ", int'(rd_occ), 0);
    wr(4, 0, 1);
    chk("top_occ_set", int'(top_occ), 1);
    wr(4, 0, 0);
    chk("top_occ_clr", int'(top_occ), 0);

    // 3: one full bottom row
    fill_row(19, 1);
    wr(0, 18, 2);
    run_clear("t3", 23, 1, 1'b0);
    sweep("t3_board", 1);

    // 4: four adjacent full rows
    for (int y = 16; y < 20; y++) fill_row(y, (y % 7) + 1);
    run_clear("t4", 29, 4, 1'b0);
    sweep("t4_board", 0);
    chk("t4_top_occ", int'(top_occ), 0);

    // 5: non-adjacent full rows with debris between
    fill_row(19, 5);
    fill_row(17, 6);
    wr(2, 18, 4);
    wr(5, 16, 3);
    run_clear("t5", 25, 2, 1'b0);
    sweep("t5_board", 2);

    // 6a: writes and restarts while busy are dropped
    wr(2, 19, 0);
    wr(5, 18, 0);
    fill_row(19, 2);
    run_clear("t6a", 23, 1, 1'b1);
    rd_chk("t6a_dropped_wr", 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("t6a_idle", int'(busy), 0);

    // 7: full row 0 is cleared to zeros
    fill_row(0, 3);
    chk("t7_top_occ", int'(top_occ), 1);
    run_clear("t7", 23, 1, 1'b0);
    chk("t7_top_clr", int'(top_occ), 0);
    sweep("t7_board", 0);

    // 6b: reset during the SHIFT cycle
    fill_row(19, 4);
    fill_row(18, 5);
    @(posedge clk); #1;
    clear_start = 1'b1;
    @(posedge clk); #1;
    clear_start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    chk("t6b_busy", int'(busy), 0);
    chk("t6b_lines", int'(lines_cleared), 0);
    sweep("t6b_board", 0);
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk("t6b_no_done", seen, 0);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
